// File: rtl/dsp_path_ctrl.sv
// Packet-aware steering between the DMA streams and two DSP engines (0 = FIR, 1 = DFT).
// One engine is latched per packet and held until both the input and output EOP have completed.
module dsp_path_ctrl #(
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_fir_enable,
    input  logic                cfg_dft_enable,
    input  logic                cfg_err_clear,
    output logic                sts_busy,
    output logic [1:0]          sts_active_sel,
    output logic [CNT_W-1:0]    sts_pkt_count,
    output logic                sts_sop_err,
    output logic                sts_timeout,
    output logic                sink_ready,
    input  logic [DATA_W-1:0]   sink_data,
    input  logic                sink_valid,
    input  logic                sink_sop,
    input  logic                sink_eop,
    output logic [DATA_W-1:0]   source_data,
    output logic                source_valid,
    output logic                source_sop,
    output logic                source_eop,
    input  logic                source_ready,
    output logic [DATA_W-1:0]   eng_sink_data,
    output logic                eng_sink_sop,
    output logic                eng_sink_eop,
    output logic [1:0]          eng_sink_valid,
    input  logic [1:0]          eng_sink_ready,
    input  logic [2*DATA_W-1:0] eng_source_data,
    input  logic [1:0]          eng_source_valid,
    input  logic [1:0]          eng_source_sop,
    input  logic [1:0]          eng_source_eop,
    output logic [1:0]          eng_source_ready
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        DRAIN_OUT = 2'd2,
        DRAIN_IN  = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [1:0]        sel_reg, sel_next;
    logic              first_reg, first_next;
    logic [WD_W-1:0]   wd_reg, wd_next;
    logic [CNT_W-1:0]  count_reg;
    logic              busy_reg;
    logic [1:0]        active_reg;
    logic              sop_err_reg;
    logic              timeout_reg;

    logic              in_active, out_active;
    logic              in_fire, in_done, out_fire, out_done;
    logic              idle_drop, enter_idle;
    logic              sop_err_set, timeout_set;

    logic [1:0]        sink_ready_term;
    logic [1:0]        src_valid_term, src_sop_term, src_eop_term;
    logic [DATA_W-1:0] src_data_term [2];
    logic [DATA_W-1:0] sel_src_data;

    assign in_active  = (state_reg == RUN) || (state_reg == DRAIN_IN);
    assign out_active = (state_reg == RUN) || (state_reg == DRAIN_OUT);

    // Per-engine steering: the unselected engine never sees valid or ready.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_eng
            assign eng_sink_valid[gi]   = in_active  & sel_reg[gi] & sink_valid;
            assign eng_source_ready[gi] = out_active & sel_reg[gi] & source_ready;
            assign sink_ready_term[gi]  = sel_reg[gi] & eng_sink_ready[gi];
            assign src_valid_term[gi]   = sel_reg[gi] & eng_source_valid[gi];
            assign src_sop_term[gi]     = sel_reg[gi] & eng_source_sop[gi];
            assign src_eop_term[gi]     = sel_reg[gi] & eng_source_eop[gi];
            assign src_data_term[gi]    = sel_reg[gi] ? eng_source_data[gi*DATA_W +: DATA_W]
                                                      : '0;
        end
    endgenerate

    assign sel_src_data = src_data_term[0] | src_data_term[1];

    assign eng_sink_data = sink_data;
    assign eng_sink_sop  = sink_sop;
    assign eng_sink_eop  = sink_eop;

    // In IDLE the only accepted beat is a stray non-SOP beat, which is dropped.
    assign idle_drop  = (state_reg == IDLE) & sink_valid & ~sink_sop;
    assign sink_ready = idle_drop | (in_active & (|sink_ready_term));

    assign source_valid = out_active & (|src_valid_term);
    assign source_sop   = out_active & (|src_sop_term);
    assign source_eop   = out_active & (|src_eop_term);
    assign source_data  = out_active ? sel_src_data : '0;

    assign in_fire  = in_active & sink_valid & sink_ready;
    assign in_done  = in_fire & sink_eop;
    assign out_fire = out_active & source_valid & source_ready;
    assign out_done = out_fire & source_eop;

    always_comb begin
        state_next  = state_reg;
        sel_next    = sel_reg;
        first_next  = first_reg;
        wd_next     = wd_reg;
        sop_err_set = 1'b0;
        timeout_set = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sink_valid && sink_sop && (cfg_fir_enable || cfg_dft_enable)) begin
                    state_next = RUN;
                    sel_next   = cfg_fir_enable ? 2'b01 : 2'b10;
                    first_next = 1'b1;
                end else if (idle_drop) begin
                    sop_err_set = 1'b1;
                end
            end
            RUN: begin
                if (in_done && out_done) begin
                    state_next = IDLE;
                end else if (in_done) begin
                    state_next = DRAIN_OUT;
                    wd_next    = '0;
                end else if (out_done) begin
                    state_next = DRAIN_IN;
                end
            end
            DRAIN_OUT: begin
                // Watchdog counts consecutive cycles without an accepted output beat.
                if (out_done) begin
                    state_next = IDLE;
                end else if (out_fire) begin
                    wd_next = '0;
                end else if (wd_reg == WD_LAST) begin
                    state_next  = IDLE;
                    timeout_set = 1'b1;
                end else begin
                    wd_next = wd_reg + 1'b1;
                end
            end
            DRAIN_IN: begin
                if (in_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (in_fire) begin
            first_next = 1'b0;
            if (sink_sop && !first_reg) begin
                sop_err_set = 1'b1;
            end
        end
        if (state_reg != IDLE && state_next == IDLE) begin
            sel_next = 2'b00;
        end
    end

    assign enter_idle = (state_reg != IDLE) && (state_next == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            sel_reg     <= 2'b00;
            first_reg   <= 1'b0;
            wd_reg      <= '0;
            count_reg   <= '0;
            busy_reg    <= 1'b0;
            active_reg  <= 2'b00;
            sop_err_reg <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            sel_reg    <= sel_next;
            first_reg  <= first_next;
            wd_reg     <= wd_next;
            busy_reg   <= (state_reg != IDLE);
            active_reg <= sel_reg;
            if (enter_idle) begin
                count_reg <= count_reg + 1'b1;
            end
            // A set event in the same cycle as a clear wins.
            if (sop_err_set) begin
                sop_err_reg <= 1'b1;
            end else if (cfg_err_clear) begin
                sop_err_reg <= 1'b0;
            end
            if (timeout_set) begin
                timeout_reg <= 1'b1;
            end else if (cfg_err_clear) begin
                timeout_reg <= 1'b0;
            end
        end
    end

    assign sts_busy       = busy_reg;
    assign sts_active_sel = active_reg;
    assign sts_pkt_count  = count_reg;
    assign sts_sop_err    = sop_err_reg;
    assign sts_timeout    = timeout_reg;

endmodule

// File: tb/tb_dsp_path_ctrl.sv
// Scoreboard bench for dsp_path_ctrl: echoing engine models, expected-beat queue and
// a decoupled output monitor; counter wrap and watchdog exercised with small parameters.
module tb_dsp_path_ctrl;

    localparam int DATA_W  = 32;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic [31:0] d;
        logic        sop;
        logic        eop;
    } beat_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                cfg_fir_enable = 1'b0;
    logic                cfg_dft_enable = 1'b0;
    logic                cfg_err_clear = 1'b0;
    logic                sts_busy;
    logic [1:0]          sts_active_sel;
    logic [CNT_W-1:0]    sts_pkt_count;
    logic                sts_sop_err;
    logic                sts_timeout;
    logic                sink_ready;
    logic [DATA_W-1:0]   sink_data = '0;
    logic                sink_valid = 1'b0;
    logic                sink_sop = 1'b0;
    logic                sink_eop = 1'b0;
    logic [DATA_W-1:0]   source_data;
    logic                source_valid;
    logic                source_sop;
    logic                source_eop;
    logic                source_ready = 1'b0;
    logic [DATA_W-1:0]   eng_sink_data;
    logic                eng_sink_sop;
    logic                eng_sink_eop;
    logic [1:0]          eng_sink_valid;
    logic [1:0]          eng_sink_ready = 2'b00;
    logic [2*DATA_W-1:0] eng_source_data = '0;
    logic [1:0]          eng_source_valid = 2'b00;
    logic [1:0]          eng_source_sop = 2'b00;
    logic [1:0]          eng_source_eop = 2'b00;
    logic [1:0]          eng_source_ready;

    dsp_path_ctrl #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_fir_enable  (cfg_fir_enable),
        .cfg_dft_enable  (cfg_dft_enable),
        .cfg_err_clear   (cfg_err_clear),
        .sts_busy        (sts_busy),
        .sts_active_sel  (sts_active_sel),
        .sts_pkt_count   (sts_pkt_count),
        .sts_sop_err     (sts_sop_err),
        .sts_timeout     (sts_timeout),
        .sink_ready      (sink_ready),
        .sink_data       (sink_data),
        .sink_valid      (sink_valid),
        .sink_sop        (sink_sop),
        .sink_eop        (sink_eop),
        .source_data     (source_data),
        .source_valid    (source_valid),
        .source_sop      (source_sop),
        .source_eop      (source_eop),
        .source_ready    (source_ready),
        .eng_sink_data   (eng_sink_data),
        .eng_sink_sop    (eng_sink_sop),
        .eng_sink_eop    (eng_sink_eop),
        .eng_sink_valid  (eng_sink_valid),
        .eng_sink_ready  (eng_sink_ready),
        .eng_source_data (eng_source_data),
        .eng_source_valid(eng_source_valid),
        .eng_source_sop  (eng_source_sop),
        .eng_source_eop  (eng_source_eop),
        .eng_source_ready(eng_source_ready)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad = 0;
    int    rx_cnt = 0;
    int    viol = 0;
    int    eng_acc [2] = '{0, 0};
    int    gap_cnt [2] = '{0, 0};
    beat_t exp_q [$];
    beat_t eq [2][$];
    logic  mon_en = 1'b1;
    logic  eng_mute = 1'b0;
    logic  eng_rdy_rand = 1'b0;
    int    eng_gap = 0;
    int    src_mode = 0;
    int    pkts_done = 0;
    int    last_stalls = 0;
    logic [1:0] mid_sel = 2'b00;

    // Engine 0 and engine 1 apply distinct transforms so the output reveals the path taken.
    function automatic logic [31:0] xform(input int e, input logic [31:0] d);
        return (e == 0) ? (d ^ 32'hA5A5_5A5A) : (d + 32'h0101_0101);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Engine models and downstream ready: drive after the edge, record handshakes at negedge.
    initial begin : engines
        beat_t nb;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                eng_sink_ready[i] = eng_rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (!eng_mute && gap_cnt[i] == 0 && eq[i].size() > 0) begin
                    eng_source_valid[i]            = 1'b1;
                    eng_source_data[i*32 +: 32]    = eq[i][0].d;
                    eng_source_sop[i]              = eq[i][0].sop;
                    eng_source_eop[i]              = eq[i][0].eop;
                end else begin
                    eng_source_valid[i]            = 1'b0;
                    eng_source_data[i*32 +: 32]    = '0;
                    eng_source_sop[i]              = 1'b0;
                    eng_source_eop[i]              = 1'b0;
                end
            end
            case (src_mode)
                0:       source_ready = 1'b1;
                1:       source_ready = ($urandom_range(0, 3) != 0);
                default: source_ready = ~source_ready;
            endcase
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (eng_sink_valid[i] && eng_sink_ready[i]) begin
                    nb.d   = xform(i, eng_sink_data);
                    nb.sop = eng_sink_sop;
                    nb.eop = eng_sink_eop;
                    eq[i].push_back(nb);
                    eng_acc[i]++;
                end
                if (eng_source_valid[i] && eng_source_ready[i]) begin
                    void'(eq[i].pop_front());
                    gap_cnt[i] = eng_gap;
                end else if (gap_cnt[i] > 0) begin
                    gap_cnt[i]--;
                end
            end
            if (eng_sink_valid == 2'b11 || eng_source_ready == 2'b11) viol++;
        end
    end

    // Output monitor: pops the scoreboard on every accepted downstream beat.
    initial begin : monitor
        beat_t eb;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && source_valid && source_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL out_extra actual=%h/%b/%b required=none",
                             source_data, source_sop, source_eop);
                end else begin
                    eb = exp_q.pop_front();
                    rx_cnt++;
                    if ({source_data, source_sop, source_eop} !== eb) begin
                        bad++;
                        $display("FAIL out_beat actual=%h/%b/%b required=%h/%b/%b",
                                 source_data, source_sop, source_eop, eb.d, eb.sop, eb.eop);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout actual=hung required=finish");
        $fatal(1, "simulation time limit");
    end

    // Called at posedge+1; returns at posedge+1 with the beat accepted and valid dropped.
    task automatic drive_beat(input beat_t bt, output int stalls, output logic ok);
        sink_data  = bt.d;
        sink_sop   = bt.sop;
        sink_eop   = bt.eop;
        sink_valid = 1'b1;
        stalls = 0;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (sink_ready) begin
                ok = 1'b1;
                break;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
    endtask

    // Expected engine follows the enables seen when the SOP is offered, FIR first.
    task automatic send_pkt(input int len, input int sop_at, input int sw_at, input int max_idle);
        int    e;
        int    st;
        int    stall_sum;
        logic  ok;
        beat_t bt;
        beat_t xb;
        e = cfg_fir_enable ? 0 : 1;
        stall_sum = 0;
        mid_sel = 2'b00;
        for (int b = 0; b < len; b++) begin
            bt.d   = $urandom;
            bt.sop = (b == 0) || (b == sop_at);
            bt.eop = (b == len - 1);
            if (!eng_mute) begin
                xb = bt;
                xb.d = xform(e, bt.d);
                exp_q.push_back(xb);
            end
            if (b == sw_at) begin
                cfg_fir_enable = 1'b0;
                cfg_dft_enable = 1'b1;
            end
            if (max_idle > 0) begin
                repeat ($urandom_range(0, max_idle)) begin
                    @(posedge clk);
                    #1;
                end
            end
            drive_beat(bt, st, ok);
            check("sink_accept", ok, 1);
            stall_sum += st;
            if (b == 4) mid_sel = sts_active_sel;
        end
        last_stalls = stall_sum;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 600; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !sts_busy) break;
        end
        check("drain_bound", (k < 600), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        cfg_err_clear = 1'b1;
        @(posedge clk);
        #1;
        cfg_err_clear = 1'b0;
    endtask

    initial begin : main
        int   a0, a1, r0, k, len, e;
        logic [1:0] en;
        beat_t bt;
        int   st;
        logic ok;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", sts_busy, 0);
        check("rst_active_sel", sts_active_sel, 0);
        check("rst_pkt_count", sts_pkt_count, 0);
        check("rst_sop_err", sts_sop_err, 0);
        check("rst_timeout", sts_timeout, 0);
        check("rst_sink_ready", sink_ready, 0);
        check("rst_source_valid", source_valid, 0);
        check("rst_source_data", source_data, 0);
        check("rst_eng_sink_valid", eng_sink_valid, 0);
        check("rst_eng_source_ready", eng_source_ready, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // FIR only, 8 beats, full throughput: one bubble on the SOP
        cfg_fir_enable = 1'b1;
        a0 = eng_acc[0]; r0 = rx_cnt;
        send_pkt(8, -1, -1, 0);
        check("first_pkt_stalls", last_stalls, 1);
        wait_idle();
        pkts_done++;
        check("pkt_count_1", sts_pkt_count, pkts_done % 16);
        check("eng0_beats_1", eng_acc[0] - a0, 8);
        check("rx_beats_1", rx_cnt - r0, 8);
        check("active_sel_after_idle", sts_active_sel, 0);

        // Both enables: FIR wins
        cfg_dft_enable = 1'b1;
        a0 = eng_acc[0]; a1 = eng_acc[1];
        send_pkt(8, -1, -1, 0);
        check("both_en_active_sel", mid_sel, 2'b01);
        wait_idle();
        pkts_done++;
        check("both_en_eng0", eng_acc[0] - a0, 8);
        check("both_en_eng1", eng_acc[1] - a1, 0);
        check("pkt_count_2", sts_pkt_count, pkts_done % 16);

        // Enables switch to DFT at beat 3: packet stays on FIR, next one goes to DFT
        cfg_dft_enable = 1'b0;
        a0 = eng_acc[0]; a1 = eng_acc[1];
        send_pkt(16, -1, 3, 0);
        wait_idle();
        pkts_done++;
        check("switch_eng0", eng_acc[0] - a0, 16);
        check("switch_eng1", eng_acc[1] - a1, 0);
        a1 = eng_acc[1];
        send_pkt(8, -1, -1, 0);
        check("next_pkt_active_sel", mid_sel, 2'b10);
        wait_idle();
        pkts_done++;
        check("next_pkt_eng1", eng_acc[1] - a1, 8);
        check("pkt_count_4", sts_pkt_count, pkts_done % 16);

        // DFT slow drain with toggling downstream ready
        eng_gap = 3;
        src_mode = 2;
        send_pkt(16, -1, -1, 0);
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain_out_bound", (k < 400), 1);
        check("busy_held_in_drain", sts_busy, 1);
        @(posedge clk);
        #1;
        wait_idle();
        pkts_done++;
        check("drain_pkt_count", sts_pkt_count, pkts_done % 16);
        check("drain_no_timeout", sts_timeout, 0);
        eng_gap = 0;
        src_mode = 0;

        // Stray non-SOP beat in IDLE is dropped and flagged
        a0 = eng_acc[0]; a1 = eng_acc[1];
        sink_data = $urandom; sink_sop = 1'b0; sink_valid = 1'b1;
        @(negedge clk);
        check("drop_sink_ready", sink_ready, 1);
        @(posedge clk);
        #1;
        sink_valid = 1'b0;
        @(negedge clk);
        check("drop_sop_err", sts_sop_err, 1);
        check("drop_not_forwarded", (eng_acc[0] - a0) + (eng_acc[1] - a1), 0);
        @(posedge clk);
        #1;
        pulse_clear();
        @(negedge clk);
        check("err_clear", sts_sop_err, 0);
        @(posedge clk);
        #1;
        sink_valid = 1'b1; cfg_err_clear = 1'b1;
        @(posedge clk);
        #1;
        sink_valid = 1'b0; cfg_err_clear = 1'b0;
        @(negedge clk);
        check("set_beats_clear", sts_sop_err, 1);
        @(posedge clk);
        #1;
        pulse_clear();

        // Repeated SOP inside a packet: flagged but forwarded
        cfg_fir_enable = 1'b1; cfg_dft_enable = 1'b0;
        send_pkt(6, 2, -1, 0);
        wait_idle();
        pkts_done++;
        check("mid_sop_err", sts_sop_err, 1);
        check("pkt_count_mid_sop", sts_pkt_count, pkts_done % 16);
        pulse_clear();

        // Engine never returns data: watchdog exit after TIMEOUT idle drain cycles
        eng_mute = 1'b1;
        send_pkt(4, -1, -1, 0);
        for (k = 1; k < 60; k++) begin
            @(negedge clk);
            if (sts_timeout) break;
        end
        check("timeout_latency", k, TIMEOUT + 1);
        eq[0].delete();
        eq[1].delete();
        eng_mute = 1'b0;
        pkts_done++;
        repeat (2) @(negedge clk);
        check("timeout_busy", sts_busy, 0);
        check("timeout_flag", sts_timeout, 1);
        check("timeout_pkt_count", sts_pkt_count, pkts_done % 16);
        @(posedge clk);
        #1;
        pulse_clear();
        @(negedge clk);
        check("timeout_clear", sts_timeout, 0);
        @(posedge clk);
        #1;

        // Randomized packets; the counter wraps along the way
        eng_rdy_rand = 1'b1;
        src_mode = 1;
        for (int p = 0; p < 24; p++) begin
            en = 2'($urandom_range(1, 3));
            cfg_fir_enable = en[0];
            cfg_dft_enable = en[1];
            e = en[0] ? 0 : 1;
            len = $urandom_range(1, 12);
            eng_gap = $urandom_range(0, 2);
            a0 = eng_acc[0]; a1 = eng_acc[1];
            send_pkt(len, -1, -1, 2);
            wait_idle();
            pkts_done++;
            check("rand_pkt_count", sts_pkt_count, pkts_done % 16);
            check("rand_sel_beats", (e == 0) ? (eng_acc[0] - a0) : (eng_acc[1] - a1), len);
            check("rand_unsel_beats", (e == 0) ? (eng_acc[1] - a1) : (eng_acc[0] - a0), 0);
        end
        check("rand_no_timeout", sts_timeout, 0);
        check("rand_no_sop_err", sts_sop_err, 0);
        check("one_hot_engine_ctrl", viol, 0);

        // Reset in the middle of a packet returns to IDLE at once
        mon_en = 1'b0;
        eng_rdy_rand = 1'b0;
        src_mode = 0;
        cfg_fir_enable = 1'b1;
        for (int b = 0; b < 3; b++) begin
            bt.d = $urandom; bt.sop = (b == 0); bt.eop = 1'b0;
            drive_beat(bt, st, ok);
        end
        check("pre_reset_busy", sts_busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", sts_busy, 0);
        check("mid_rst_active_sel", sts_active_sel, 0);
        check("mid_rst_pkt_count", sts_pkt_count, 0);
        check("mid_rst_eng_sink_valid", eng_sink_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dsp_path_ctrl.md
# dsp_path_ctrl

Packet-aware path controller between the DMA streaming interfaces and the DSP processing engines (engine 0 = FIR filter wrapper, engine 1 = DFT wrapper). It samples the CSR engine-enable bits only between packets and latches one engine per packet. It then steers the upstream sink stream into that engine and returns that engine's source stream downstream. The selection is held until both the input EOP and the output EOP have completed, so a CSR write can never split a packet across engines. It also provides packet-count, busy, protocol-error and drain-timeout status for the CSR block.

## Interface
Parameters:
- DATA_W, 32, stream data width
- CNT_W, 16, completed-packet counter width
- TIMEOUT, 4096, maximum idle cycles allowed on the output during drain

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_fir_enable  in  1  CSR request for engine 0
- cfg_dft_enable  in  1  CSR request for engine 1
- cfg_err_clear  in  1  single-cycle pulse; clears the sticky status bits
- sts_busy  out  1  high in every state except IDLE
- sts_active_sel  out  2  one-hot latched engine; 00 = none
- sts_pkt_count  out  CNT_W  number of completed packets; wraps
- sts_sop_err  out  1  sticky protocol-error flag
- sts_timeout  out  1  sticky drain-timeout flag
- sink_ready  out  1  ready to the upstream stream
- sink_data  in  DATA_W, sink_valid  in  1, sink_sop  in  1, sink_eop  in  1  upstream stream
- source_data  out  DATA_W, source_valid  out  1, source_sop  out  1, source_eop  out  1  downstream stream
- source_ready  in  1  ready from downstream
- eng_sink_data  out  DATA_W, eng_sink_sop  out  1, eng_sink_eop  out  1  sink data/SOP/EOP broadcast to both engines
- eng_sink_valid  out  2  valid to each engine; only the selected bit can be high
- eng_sink_ready  in  2  ready from each engine
- eng_source_data  in  2*DATA_W  engine output data; engine 0 in bits [DATA_W-1:0]
- eng_source_valid  in  2, eng_source_sop  in  2, eng_source_eop  in  2  engine output stream
- eng_source_ready  out  2  ready to each engine; only the selected bit can be high

## Operation
- States: IDLE, RUN, DRAIN_OUT (input EOP done, output pending), DRAIN_IN (output EOP done, input pending).
- IDLE:
  - sink_ready = 0.
  - If sink_valid & sink_sop & (fir|dft): latch sel, with FIR taking priority over DFT; go to RUN.
  - If sink_valid & !sink_sop: set sink_ready = 1 to drop the beat and set sts_sop_err.
  - If both enables are 0: hold.
- RUN / DRAIN_IN, input path:
  - sink_ready = eng_sink_ready[sel]; eng_sink_valid[sel] = sink_valid.
  - An accepted beat with sink_eop marks the input side done.
  - An accepted beat with sink_sop after the first beat sets sts_sop_err; the beat is still forwarded.
- RUN / DRAIN_OUT, output path:
  - source_* = eng_source_*[sel]; eng_source_ready[sel] = source_ready.
  - An accepted beat with eop marks the output side done.
- Transitions:
  - RUN → DRAIN_OUT on input done; RUN → DRAIN_IN on output done.
  - RUN → IDLE when input and output both complete in the same cycle.
  - DRAIN_OUT → IDLE on output done; DRAIN_IN → IDLE on input done.
- sts_pkt_count increments on every transition into IDLE, including timeout exits. It wraps from 2^CNT_W−1 to 0.
- DRAIN_OUT watchdog:
  - The counter clears on entry and on every accepted output beat; otherwise it increments.
  - When it reaches TIMEOUT: go to IDLE and set sts_timeout.
- Outside the states where each side is active, its valid and ready outputs are 0, and source_data is 0.
- The unselected engine always sees valid = 0 and ready = 0.
- CSR enables are ignored outside IDLE. Clearing both enables mid-packet does not abort the packet.
- cfg_err_clear clears both sticky bits. If a set event occurs in the same cycle, the set wins.

## Timing
- Reset values: state IDLE; all outputs 0; sel = 00; counters 0.
- The SOP beat sees sink_ready = 0 in the IDLE cycle and is accepted no earlier than the first RUN cycle, giving one bubble per packet.
- In RUN and the drain states, data, valid and ready pass through combinationally with zero latency. No registers sit in the data path.
- sts_active_sel and sts_busy are registered and change the cycle after the state transition.
- Reset asserted mid-packet returns the block to IDLE immediately. Engines and the DMA are reset by the same rst_n.

## Test plan
- FIR enabled; one 8-beat packet, with source_ready always 1 and the engine echoing beats → sink_ready low for exactly 1 cycle, 8 beats returned, sts_pkt_count = 1, state back in IDLE.
- Both enables = 1; one packet → only eng_sink_valid[0] toggles; sts_active_sel = 01.
- Enables switched from FIR to DFT at beat 3 of a 16-beat packet → the whole packet goes to engine 0; the next packet goes to engine 1.
- DFT: input EOP at cycle t, output EOP 64 cycles later with source_ready toggling → stays in DRAIN_OUT until the output EOP, then IDLE; count increments once.
- Non-SOP beat in IDLE → beat dropped, sts_sop_err = 1; cfg_err_clear pulse → 0; simultaneous clear and new error → stays 1.
- TIMEOUT = 16; engine never emits EOP after input EOP → IDLE after 16 idle cycles, sts_timeout = 1. sts_pkt_count starting at 0xFFFF wraps to 0.
